pcm_cmd_seq: RTL and testbench

- Parametrised command sequencer for the board's parallel PCM/NOR flash (Intel/Micron command set).
- Accepts one operation per start pulse (read array word, unlock+program word, read status, clear status) and generates CE#/OE#/WE#/address/DQ bus cycles with programmable timing.
- Polls the status register until ready, then reports data/status/error through a start/done handshake.
- Sits between user control logic (switch/LED test tops, future loaders) and the top-level DQ tri-state buffer.

---
 rtl/pcm_cmd_seq_if.sv | 37 +++
 rtl/pcm_cmd_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_pcm_cmd_seq.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_cmd_seq_if.sv
// User-side handshake plus flash bus of the PCM/NOR command sequencer.
// master = user logic and the top-level DQ buffer, slave = sequencer.
interface pcm_cmd_seq_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        status;
  logic              err;
  logic              timeout;
  logic              mem_ce_n;
  logic              mem_oe_n;
  logic              mem_we_n;
  logic              mem_rst_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dq_o;
  logic              mem_dq_oe;
  logic [DATA_W-1:0] mem_dq_i;

  modport master (
    output start, op, addr_in, wdata_in, mem_dq_i,
    input  busy, done, rdata, status, err, timeout,
    input  mem_ce_n, mem_oe_n, mem_we_n, mem_rst_n, mem_addr, mem_dq_o, mem_dq_oe
  );

  modport slave (
    input  start, op, addr_in, wdata_in, mem_dq_i,
    output busy, done, rdata, status, err, timeout,
    output mem_ce_n, mem_oe_n, mem_we_n, mem_rst_n, mem_addr, mem_dq_o, mem_dq_oe
  );
endinterface

// File: rtl/pcm_cmd_seq.sv
// Command sequencer for parallel NOR flash (Intel/Micron command set):
// one op per start, timed CE#/OE#/WE# bus cycles, status polling, done pulse.
//
// state  | meaning
// IDLE   | waiting for start
// W_ACT  | write strobe low, command/data driven
// W_REC  | strobes high, DQ still driven for hold time
// R_ACT  | read strobe low, DQ sampled on last clock
// R_REC  | strobes high after a read
// NEXT   | choose next step / poll decision
// DONE   | one-clock completion pulse
module pcm_cmd_seq #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int WR_CYC   = 6,
  parameter int RD_CYC   = 11,
  parameter int RCV_CYC  = 1,
  parameter int POLL_MAX = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  pcm_cmd_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_W_ACT, S_W_REC, S_R_ACT, S_R_REC, S_NEXT, S_DONE
  } state_t;

  localparam int CYC_A   = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int CYC_MAX = (CYC_A > RCV_CYC) ? CYC_A : RCV_CYC;
  localparam int CNT_W   = $clog2(CYC_MAX + 1);
  localparam int PW      = $clog2(POLL_MAX + 1);
  localparam logic [2:0] POLL_STEP = 3'd5;

  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [7:0]        status_q, status_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d, timeout_q, timeout_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d, mem_rst_n_q, mem_rst_n_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;

  function automatic logic step_is_read(input logic [1:0] op, input logic [2:0] step);
    return ((op == 2'd0 || op == 2'd2) && step == 3'd1) || (op == 2'd1 && step == POLL_STEP);
  endfunction

  function automatic logic [2:0] last_step(input logic [1:0] op);
    case (op)
      2'd0:    return 3'd1;
      2'd1:    return 3'd6;
      2'd2:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] cmd_word(input logic [1:0] op, input logic [2:0] step,
                                                 input logic [DATA_W-1:0] wdata);
    logic [7:0] c;
    c = 8'hFF;
    case (op)
      2'd1: case (step)
              3'd0:    c = 8'h60;
              3'd1:    c = 8'hD0;
              3'd2:    c = 8'h40;
              3'd4:    c = 8'h70;
              default: c = 8'hFF;
            endcase
      2'd2:    c = 8'h70;
      2'd3:    c = 8'h50;
      default: c = 8'hFF;
    endcase
    if (op == 2'd1 && step == 3'd3) return wdata;
    return DATA_W'(c);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      poll_q      <= '0;
      status_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_o_q      <= '0;
      mem_rst_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      poll_q      <= poll_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_o_q      <= dq_o_d;
      mem_rst_n_q <= mem_rst_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    poll_d    = poll_q;
    status_d  = status_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d   = S_W_ACT;
        step_d    = '0;
        op_d      = bus.op;
        addr_d    = bus.addr_in;
        wdata_d   = bus.wdata_in;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        poll_d    = '0;
      end
      S_W_ACT: if (cnt_q == '0) state_d = S_W_REC;
      S_W_REC: if (cnt_q == '0) state_d = S_NEXT;
      S_R_ACT: if (cnt_q == '0) begin
        state_d = S_R_REC;
        if (op_q == 2'd1) begin
          status_d = bus.mem_dq_i[7:0];
          poll_d   = poll_q + PW'(1);
        end else if (op_q == 2'd2) begin
          status_d = bus.mem_dq_i[7:0];
          rdata_d  = bus.mem_dq_i;
        end else begin
          rdata_d  = bus.mem_dq_i;
        end
      end
      S_R_REC: if (cnt_q == '0) state_d = S_NEXT;
      S_NEXT: begin
        if (op_q == 2'd1 && step_q == POLL_STEP) begin
          // SR7 wins over timeout when the last permitted read reports ready
          if (status_q[7] || poll_q == PW'(POLL_MAX)) begin
            state_d   = S_W_ACT;
            step_d    = step_q + 3'd1;
            timeout_d = !status_q[7];
            err_d     = !status_q[7] | status_q[5] | status_q[4] | status_q[3] | status_q[1];
          end else begin
            state_d = S_R_ACT;
          end
        end else if (step_q == last_step(op_q)) begin
          state_d = S_DONE;
          if (op_q == 2'd2) err_d = status_q[5] | status_q[4] | status_q[3] | status_q[1];
        end else begin
          step_d  = step_q + 3'd1;
          state_d = step_is_read(op_q, step_q + 3'd1) ? S_R_ACT : S_W_ACT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        S_W_ACT:          cnt_d = CNT_W'(WR_CYC - 1);
        S_R_ACT:          cnt_d = CNT_W'(RD_CYC - 1);
        S_W_REC, S_R_REC: cnt_d = CNT_W'(RCV_CYC - 1);
        default:          cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Outputs decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_o_d      = dq_o_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_rst_n_d = 1'b1;
    case (state_d)
      S_W_ACT: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        dq_o_d  = cmd_word(op_d, step_d, wdata_d);
        busy_d  = 1'b1;
      end
      S_W_REC: begin
        dq_oe_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_R_ACT: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        busy_d = 1'b1;
      end
      S_R_REC, S_NEXT: busy_d = 1'b1;
      S_DONE:          done_d = 1'b1;
      default:         busy_d = 1'b0;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.status    = status_q;
  assign bus.err       = err_q;
  assign bus.timeout   = timeout_q;
  assign bus.mem_ce_n  = ce_n_q;
  assign bus.mem_oe_n  = oe_n_q;
  assign bus.mem_we_n  = we_n_q;
  assign bus.mem_rst_n = mem_rst_n_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_dq_o  = dq_o_q;
  assign bus.mem_dq_oe = dq_oe_q;
endmodule

// File: tb/tb_pcm_cmd_seq.sv
// Bench for pcm_cmd_seq: vector table of ops, flash bus scoreboard with a
// small status/array model, plus reset-abort and ignored-start sequences.
module tb_pcm_cmd_seq;
  localparam int AW = 24, DW = 16;
  localparam int WR_CYC = 6, RD_CYC = 11, RCV_CYC = 1, POLL_MAX = 4;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcm_cmd_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pcm_cmd_seq #(
    .ADDR_W(AW), .DATA_W(DW), .WR_CYC(WR_CYC), .RD_CYC(RD_CYC),
    .RCV_CYC(RCV_CYC), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    bit         wr;
    logic [15:0] data;
    int         len;
    int         oelen;
    logic [23:0] addr;
  } txn_t;

  typedef struct {
    logic [1:0]  op;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] arr;
    int          zeros;
    logic [7:0]  sr;
    logic [15:0] exp_rdata;
    logic [7:0]  exp_status;
    bit          exp_err;
    bit          exp_to;
  } vec_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  int done_cnt = 0, proto_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // flash model state
  bit          st_mode = 1'b0;
  int          sr_idx = 0, m_zeros = 0;
  logic [7:0]  m_sr = 8'h00;
  logic [15:0] m_arr = 16'h0000;

  function automatic logic [15:0] model_dq();
    if (st_mode) return {8'h3C, (sr_idx < m_zeros) ? 8'h00 : m_sr};
    return m_arr;
  endfunction

  // bus monitor
  int mon_wlen = 0, mon_rlen = 0, mon_oelen = 0;
  logic [15:0] mon_wd = '0;
  logic [23:0] mon_wa = '0, mon_ra = '0;
  always @(negedge clk) begin
    txn_t t;
    if (bus.mem_we_n === 1'b0 && bus.mem_oe_n === 1'b0) proto_err++;
    if (bus.mem_dq_oe === 1'b1 && bus.mem_oe_n === 1'b0) proto_err++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.mem_ce_n === 1'b0 && bus.mem_we_n === 1'b0) begin
      mon_wlen++;
      mon_wd = bus.mem_dq_o;
      mon_wa = bus.mem_addr;
    end
    if (bus.mem_dq_oe === 1'b1) mon_oelen++;
    else if (mon_oelen > 0) begin
      t = '{wr: 1'b1, data: mon_wd, len: mon_wlen, oelen: mon_oelen, addr: mon_wa};
      obs_q.push_back(t);
      if (mon_wd == 16'h0070) st_mode = 1'b1;
      else if (mon_wd == 16'h00FF) st_mode = 1'b0;
      bus.mem_dq_i = model_dq();
      mon_wlen = 0;
      mon_oelen = 0;
    end
    if (bus.mem_ce_n === 1'b0 && bus.mem_oe_n === 1'b0) begin
      mon_rlen++;
      mon_ra = bus.mem_addr;
    end else if (mon_rlen > 0) begin
      t = '{wr: 1'b0, data: 16'h0, len: mon_rlen, oelen: 0, addr: mon_ra};
      obs_q.push_back(t);
      if (st_mode) sr_idx++;
      bus.mem_dq_i = model_dq();
      mon_rlen = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [15:0] d, input logic [23:0] a, inout int lat);
    exp_q.push_back('{wr: 1'b1, data: d, len: WR_CYC, oelen: WR_CYC + RCV_CYC, addr: a});
    lat += WR_CYC + RCV_CYC + 1;
  endtask

  task automatic push_r(input logic [23:0] a, inout int lat);
    exp_q.push_back('{wr: 1'b0, data: 16'h0, len: RD_CYC, oelen: 0, addr: a});
    lat += RD_CYC + RCV_CYC + 1;
  endtask

  task automatic push_exp(input vec_t v, output int lat);
    int n;
    lat = 0;
    case (v.op)
      2'd0: begin push_w(16'h00FF, v.addr, lat); push_r(v.addr, lat); end
      2'd1: begin
        push_w(16'h0060, v.addr, lat);
        push_w(16'h00D0, v.addr, lat);
        push_w(16'h0040, v.addr, lat);
        push_w(v.wdata, v.addr, lat);
        push_w(16'h0070, v.addr, lat);
        n = (v.zeros < POLL_MAX) ? v.zeros + 1 : POLL_MAX;
        for (int k = 0; k < n; k++) push_r(v.addr, lat);
        push_w(16'h00FF, v.addr, lat);
      end
      2'd2: begin push_w(16'h0070, v.addr, lat); push_r(v.addr, lat); end
      default: push_w(16'h0050, v.addr, lat);
    endcase
  endtask

  task automatic compare_bus(input string tag);
    txn_t o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s bus: unexpected wr=%0d data=%h len=%0d", tag, o.wr, o.data, o.len);
      end else begin
        e = exp_q.pop_front();
        if (o.wr != e.wr || o.len != e.len || o.oelen != e.oelen || o.addr !== e.addr ||
            (e.wr && o.data !== e.data)) begin
          failures++;
          $display("FAIL %s bus: got wr=%0d data=%h len=%0d oe=%0d addr=%h expected wr=%0d data=%h len=%0d oe=%0d addr=%h",
                   tag, o.wr, o.data, o.len, o.oelen, o.addr, e.wr, e.data, e.len, e.oelen, e.addr);
        end
      end
    end
    check({tag, " missing_cycles"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_start(input logic [1:0] op, input logic [23:0] a, input logic [15:0] wd,
                          output int c0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op = op;
    bus.addr_in = a;
    bus.wdata_in = wd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int c0, input int exp_lat);
    int n;
    @(negedge clk);
    check({tag, " busy_after_start"}, bus.busy, 1);
    n = 0;
    while (bus.done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done_seen"}, bus.done, 1);
    check({tag, " latency"}, cyc - c0, exp_lat);
    check({tag, " busy_at_done"}, bus.busy, 0);
    @(negedge clk);
    check({tag, " done_one_clk"}, bus.done, 0);
  endtask

  task automatic set_model(input vec_t v);
    st_mode = 1'b0;
    sr_idx = 0;
    m_zeros = v.zeros;
    m_sr = v.sr;
    m_arr = v.arr;
    bus.mem_dq_i = model_dq();
  endtask

  vec_t vecs[10];

  initial begin
    int c0, lat, d0;
    vec_t v;
    string tag;

    vecs[0] = '{2'd3, 24'h100000, 16'h0000, 16'h0000, 0,   8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{2'd0, 24'h100000, 16'h0000, 16'hA5C3, 0,   8'h00, 16'hA5C3, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{2'd1, 24'h020040, 16'h5552, 16'h0000, 3,   8'h80, 16'h0000, 8'h80, 1'b0, 1'b0};
    vecs[3] = '{2'd1, 24'h020041, 16'h1234, 16'h0000, 0,   8'h90, 16'h0000, 8'h90, 1'b1, 1'b0};
    vecs[4] = '{2'd1, 24'h020042, 16'hBEEF, 16'h0000, 100, 8'h80, 16'h0000, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{2'd2, 24'h000000, 16'h0000, 16'h0000, 0,   8'hA2, 16'h3CA2, 8'hA2, 1'b1, 1'b0};
    vecs[6] = '{2'd0, 24'hFFFFFF, 16'h0000, 16'h5A3C, 0,   8'h00, 16'h5A3C, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{2'd2, 24'h0ABCDE, 16'h0000, 16'h0000, 0,   8'h80, 16'h3C80, 8'h80, 1'b0, 1'b0};
    vecs[8] = '{2'd1, 24'h000777, 16'h00A0, 16'h0000, 1,   8'h82, 16'h0000, 8'h82, 1'b1, 1'b0};
    vecs[9] = '{2'd3, 24'h000001, 16'h0000, 16'h0000, 0,   8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.addr_in = '0;
    bus.wdata_in = '0;
    bus.mem_dq_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_dq_oe, bus.mem_rst_n}, 5'b11101);
    check("reset addr", bus.mem_addr, 0);
    check("reset dq_o", bus.mem_dq_o, 0);
    check("reset flags", {bus.busy, bus.done, bus.err, bus.timeout}, 0);
    check("reset data", {bus.rdata, bus.status}, 0);

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      set_model(v);
      push_exp(v, lat);
      do_start(v.op, v.addr, v.wdata, c0);
      wait_done(tag, c0, lat);
      check({tag, " err"}, bus.err, v.exp_err);
      check({tag, " timeout"}, bus.timeout, v.exp_to);
      if (v.op == 2'd0 || v.op == 2'd2) check({tag, " rdata"}, bus.rdata, v.exp_rdata);
      if (v.op == 2'd1 || v.op == 2'd2) check({tag, " status"}, bus.status, v.exp_status);
      compare_bus(tag);
    end

    // reset during the first write cycle of a program op
    v = vecs[2];
    set_model(v);
    d0 = done_cnt;
    exp_q.push_back('{wr: 1'b1, data: 16'h0060, len: 4, oelen: 4, addr: 24'h0C0C0C});
    do_start(2'd1, 24'h0C0C0C, 16'h1111, c0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_dq_oe}, 4'b1110);
    check("abort flags", {bus.busy, bus.done, bus.err, bus.timeout}, 0);
    check("abort data", {bus.rdata, bus.status}, 0);
    repeat (30) @(negedge clk);
    check("abort no_done", done_cnt - d0, 0);
    compare_bus("abort");

    // start during an op is ignored
    v = vecs[0];
    set_model(v);
    d0 = done_cnt;
    lat = 0;
    push_w(16'h0050, 24'h003210, lat);
    do_start(2'd3, 24'h003210, 16'h0000, c0);
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.addr_in = 24'h00FFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("busy_start", c0 - 1, lat + 1);
    repeat (40) @(negedge clk);
    check("busy_start done_count", done_cnt - d0, 1);
    check("busy_start idle", bus.busy, 0);
    compare_bus("busy_start");

    check("protocol", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
